// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the fetch/data memory-port sequencer.
package arm_mem_pkg;

   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_DATA  = 3'd3,
      ST_WB    = 3'd4,
      ST_HALT  = 3'd5
   } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Per-access wait counter: counts cycles without mem_ready and flags the
// cycle in which the TIMEOUT-th consecutive wait occurs.
module mem_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired
);

   localparam int              CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   FULL = CW'(TIMEOUT);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count && (r_count != FULL)) begin
         r_count <= r_count + CW'(1);
      end
   end

   // Combinational so that a ready arriving in the same cycle can still win.
   assign o_expired = i_count && (r_count == LAST);

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one single-port memory between instruction fetch and LDR/STR data
// accesses, stalling the CPU except for one cycle per retired instruction.
//
// state | meaning
// IDLE  | one cycle after reset, CPU stalled
// FETCH | read instruction at pc, wait for mem_ready
// EXEC  | instruction latched; non-memory instr retires here
// DATA  | load/store at data_memory_addr, wait for mem_ready
// WB    | memory instr retires, CPU unstalled
// HALT  | access timed out; bus_err set, held until reset
module mem_port_sequencer
   import arm_mem_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_memory_addr,
   input  logic [31:0] write_data,
   output logic [31:0] instr,
   output logic [31:0] read_data,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] retired,
   output logic        bus_err
);

   mem_state_t  r_state;
   mem_state_t  w_next;
   logic [31:0] r_instr;
   logic [31:0] r_read_data;
   logic [31:0] r_retired;
   logic        r_bus_err;
   logic        w_access;
   logic        w_expired;
   logic        w_retire;

   assign w_access = (r_state == ST_FETCH) || (r_state == ST_DATA);
   assign w_retire = ((r_state == ST_EXEC) && !data_req) || (r_state == ST_WB);

   // Counter sits at zero outside FETCH/DATA, so each access starts fresh.
   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .rst_n     (reset),
      .i_clear   (!w_access),
      .i_count   (w_access && !mem_ready),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  w_next = ST_FETCH;
         ST_FETCH: begin
            if (mem_ready)      w_next = ST_EXEC;
            else if (w_expired) w_next = ST_HALT;
         end
         ST_EXEC:  w_next = data_req ? ST_DATA : ST_FETCH;
         ST_DATA:  begin
            if (mem_ready)      w_next = ST_WB;
            else if (w_expired) w_next = ST_HALT;
         end
         ST_WB:    w_next = ST_FETCH;
         ST_HALT:  w_next = ST_HALT;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      cpu_stall = 1'b1;
      case (r_state)
         ST_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
         end
         ST_EXEC:  cpu_stall = data_req;
         ST_DATA:  begin
            mem_req   = 1'b1;
            mem_we    = data_we;
            mem_addr  = data_memory_addr;
            mem_wdata = write_data;
         end
         ST_WB:    cpu_stall = 1'b0;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instr     <= 32'd0;
         r_read_data <= 32'd0;
         r_retired   <= 32'd0;
         r_bus_err   <= 1'b0;
      end else begin
         if ((r_state == ST_FETCH) && mem_ready) begin
            r_instr <= mem_rdata;
         end
         if ((r_state == ST_DATA) && mem_ready && !data_we) begin
            r_read_data <= mem_rdata;
         end
         if (w_retire) begin
            r_retired <= r_retired + 32'd1;
         end
         if (w_access && w_expired) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   assign instr     = r_instr;
   assign read_data = r_read_data;
   assign retired   = r_retired;
   assign bus_err   = r_bus_err;

endmodule

// File: doc/mem_port_sequencer.md
MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max mem_ready wait cycles per access before bus error.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: pc  in  32  CPU fetch address.
REQ-005 SHALL have ports: data_req  in  1  CPU current instr is LDR/STR, decoded combinationally from instr.
REQ-006 SHALL have ports: data_we  in  1  1=STR, 0=LDR.
REQ-007 SHALL have ports: data_memory_addr  in  32  CPU data address.
REQ-008 SHALL have ports: write_data  in  32  CPU store data.
REQ-009 SHALL have ports: instr  out  32  latched instruction to CPU.
REQ-010 SHALL have ports: read_data  out  32  latched load data to CPU.
REQ-011 SHALL have ports: cpu_stall  out  1  1=CPU holds PC, register file, flags.
REQ-012 SHALL have ports: mem_req, mem_we  out  1 each  single-port memory request/write strobe.
REQ-013 SHALL have ports: mem_addr, mem_wdata  out  32 each  memory address/write data.
REQ-014 SHALL have ports: mem_rdata  in  32; mem_ready  in  1  access complete this cycle.
REQ-015 SHALL have ports: retired  out  32  retired-instruction count; bus_err  out  1  sticky timeout flag.

Function
REQ-016 SHALL share one memory port between fetch and data using FSM states IDLE, FETCH, EXEC, DATA, WB, HALT.
REQ-017 IDLE: mem_req=0, stall=1; next cycle -> FETCH unconditionally.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready, instr<=mem_rdata, -> EXEC.
REQ-019 EXEC: mem_req=0; if data_req -> DATA with stall=1; else cpu_stall=0 for this one cycle, retired+1, -> FETCH.
REQ-020 DATA: mem_req=1, mem_addr=data_memory_addr, mem_we=data_we, mem_wdata=write_data; on mem_ready, read_data<=mem_rdata (LDR only; STR leaves read_data unchanged), -> WB.
REQ-021 WB: cpu_stall=0 one cycle, retired+1, -> FETCH.
REQ-022 cpu_stall SHALL be 1 in every state/cycle not named in REQ-019/REQ-021; exactly one unstalled cycle per instruction.
REQ-023 Minimum latency: non-memory instr 2 cycles (FETCH+EXEC), memory instr 4 cycles, with zero-wait memory.
REQ-024 mem_addr/mem_we/mem_wdata SHALL be stable while mem_req=1; outputs are 0 when mem_req=0.
REQ-025 Wait counter SHALL clear on entry to FETCH/DATA, increment each cycle mem_ready=0; reaching TIMEOUT -> HALT, bus_err<=1.
REQ-026 mem_ready in same cycle as timeout expiry SHALL win (normal transition, no error).
REQ-027 mem_ready in IDLE/EXEC/WB/HALT SHALL be ignored.
REQ-028 HALT: mem_req=0, stall=1, held until reset; bus_err sticky.
REQ-029 retired SHALL wrap 0xFFFFFFFF -> 0 without flag.

Reset
REQ-030 reset low SHALL immediately force state=IDLE, mem_req=0, mem_we=0, cpu_stall=1, instr=0, read_data=0, retired=0, bus_err=0, wait counter=0.
REQ-031 Reset mid-access SHALL abandon the access; no instr/read_data update, no retire.
REQ-032 First FETCH of pc SHALL occur the second rising edge after reset deassertion (IDLE one cycle).

Structure
REQ-033 Shared package arm_mem_pkg SHALL hold the FSM state enum type and default TIMEOUT constant.
REQ-034 Wait counter SHALL be sub-module mem_wait_timer (clear, count, expired), width clog2(TIMEOUT+1).

Verification
REQ-035 Zero-wait ADD stream, pc=0,4,8: each instr unstalled exactly every 2nd cycle; retired=3 after 6 cycles.
REQ-036 LDR, mem_rdata=0xFFFFFFFF, 2 wait cycles each phase: read_data=0xFFFFFFFF in WB, stall low only in WB, 8 cycles total.
REQ-037 STR addr=0xFF, data=7: DATA phase mem_we=1, mem_addr=0xFF, mem_wdata=7; read_data unchanged.
REQ-038 mem_ready held 0, TIMEOUT=16: HALT, bus_err=1 after 16 FETCH cycles; ready on 16th cycle -> no error.
REQ-039 reset asserted during DATA wait: mem_req=0 same cycle, retired=0; restart fetches pc after 2 edges.
REQ-040 retired preset near 0xFFFFFFFF via force, one retire -> 0.
